// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// decoder_pkg : FSM state encoding, mode constants and a counter-width helper
//               shared by decoder_nxm_scan and its dwell timer.
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Counter width that can hold 0..dwell-1, never narrower than one bit.
   function automatic int cnt_width(input int dwell);
      return (dwell > 1) ? $clog2(dwell) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_nxm_scan_if.sv
`default_nettype none
// ============================================================================
// decoder_nxm_scan_if : control and decoded-output bundle for decoder_nxm_scan.
//                       master = control logic, slave = decoder.
// Revision            : 1.0 - initial release
// ============================================================================
interface decoder_nxm_scan_if #(
   parameter int N = 3
) ();

   logic                en;
   logic                load;
   logic                mode;
   logic [N-1:0]        sel;
   logic [(2**N)-1:0]   y;
   logic [N-1:0]        cur;
   logic                busy;
   logic                wrap;

   modport master (
      output en, load, mode, sel,
      input  y, cur, busy, wrap
   );

   modport slave (
      input  en, load, mode, sel,
      output y, cur, busy, wrap
   );

endinterface
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ============================================================================
// dwell_timer : counts 0..DWELL-1 while run is high; tick marks the last count
//               and the counter folds back to zero on that same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module dwell_timer
   import decoder_pkg::*;
#(
   parameter int DWELL = 4
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic clr,
   input  wire logic run,
   output logic      tick
);

   localparam int              c_CW   = cnt_width(DWELL);
   localparam logic [c_CW-1:0] c_LAST = c_CW'(DWELL - 1);

   logic [c_CW-1:0] r_cnt;
   logic            w_last;

   assign w_last = (r_cnt == c_LAST);
   assign tick   = run & w_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr || tick) begin
         r_cnt <= '0;
      end else if (run) begin
         r_cnt <= r_cnt + c_CW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/decoder_nxm_scan.sv
`default_nettype none
// ============================================================================
// decoder_nxm_scan : registered N-to-2^N one-hot decoder with direct and
//                    auto-scan modes. Build option DECODER_ACTIVE_LOW_EN
//                    drives y one-cold (inactive level all ones).
// Revision         : 1.0 - initial release
// ============================================================================
module decoder_nxm_scan
   import decoder_pkg::*;
#(
   parameter int N     = 3,
   parameter int DWELL = 4
) (
   input  wire logic          clk,
   input  wire logic          rst,
   decoder_nxm_scan_if.slave  bus
);

   localparam int OUTS = 2**N;

`ifdef DECODER_ACTIVE_LOW_EN
   localparam logic [OUTS-1:0] c_Y_MASK = '1;
`else
   localparam logic [OUTS-1:0] c_Y_MASK = '0;
`endif

   state_t          r_state;
   logic [OUTS-1:0] r_y;
   logic [N-1:0]    r_cur;
   logic            r_busy;
   logic            r_wrap;

   logic            w_run;
   logic            w_clr;
   logic            w_tick;
   logic [N-1:0]    w_cur_nxt;
   logic [OUTS-1:0] w_sel_y;
   logic [OUTS-1:0] w_nxt_y;

   // The timer only advances on edges where the FSM would act on a tick,
   // so a load or enable drop always restarts the dwell from zero.
   assign w_run     = bus.en & ~bus.load & (r_state == ST_SCAN);
   assign w_clr     = ~bus.en | bus.load;
   assign w_cur_nxt = r_cur + N'(1);
   assign w_sel_y   = (OUTS'(1) << bus.sel) ^ c_Y_MASK;
   assign w_nxt_y   = (OUTS'(1) << w_cur_nxt) ^ c_Y_MASK;

   dwell_timer #(
      .DWELL (DWELL)
   ) u_dwell_timer (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_clr),
      .run   (w_run),
      .tick  (w_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_y     <= c_Y_MASK;
         r_cur   <= '0;
         r_busy  <= 1'b0;
         r_wrap  <= 1'b0;
      end else if (!bus.en) begin
         r_state <= ST_IDLE;
         r_y     <= c_Y_MASK;
         r_busy  <= 1'b0;
         r_wrap  <= 1'b0;
      end else if (bus.load) begin
         r_cur  <= bus.sel;
         r_y    <= w_sel_y;
         r_wrap <= 1'b0;
         if (bus.mode == MODE_SCAN) begin
            r_state <= ST_SCAN;
            r_busy  <= 1'b1;
         end else begin
            r_state <= ST_DIRECT;
            r_busy  <= 1'b0;
         end
      end else begin
         r_wrap <= 1'b0;
         case (r_state)
            ST_SCAN: begin
               if (w_tick) begin
                  r_cur  <= w_cur_nxt;
                  r_y    <= w_nxt_y;
                  r_wrap <= &r_cur;
               end
            end
            ST_DIRECT: begin
               r_y <= r_y;
            end
            default: begin
               r_state <= ST_IDLE;
               r_y     <= c_Y_MASK;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.y    = r_y;
   assign bus.cur  = r_cur;
   assign bus.busy = r_busy;
   assign bus.wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_decoder_nxm_scan.sv
`default_nettype none
// ============================================================================
// tb_decoder_nxm_scan : directed checks of decoder_nxm_scan, one instance with
//                       DWELL=4 and one with DWELL=1.
// Revision            : 1.0 - initial release
// ============================================================================
module tb_decoder_nxm_scan;

`ifdef DECODER_ACTIVE_LOW_EN
   localparam logic [7:0] c_MASK = 8'hFF;
`else
   localparam logic [7:0] c_MASK = 8'h00;
`endif

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   decoder_nxm_scan_if #(.N(3)) ifa ();
   decoder_nxm_scan_if #(.N(3)) ifb ();

   decoder_nxm_scan #(.N(3), .DWELL(4)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   decoder_nxm_scan #(.N(3), .DWELL(1)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] ye(input int idx);
      logic [7:0] v;
      v = 8'(1) << idx;
      return v ^ c_MASK;
   endfunction

   initial begin
      int exp_cur;
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      ifa.en = 1'b0; ifa.load = 1'b0; ifa.mode = 1'b0; ifa.sel = 3'd0;
      ifb.en = 1'b0; ifb.load = 1'b0; ifb.mode = 1'b0; ifb.sel = 3'd0;
      repeat (2) cyc();
      rst = 1'b0;

      check("rst_y",    32'(ifa.y),    32'(c_MASK));
      check("rst_cur",  32'(ifa.cur),  32'd0);
      check("rst_busy", 32'(ifa.busy), 32'd0);
      check("rst_wrap", 32'(ifa.wrap), 32'd0);
      check("rst_y_b",  32'(ifb.y),    32'(c_MASK));

      // Direct load, then an asynchronous reset between clock edges.
      ifa.en = 1'b1; ifa.load = 1'b1; ifa.mode = 1'b0; ifa.sel = 3'd5;
      cyc();
      ifa.load = 1'b0;
      check("pre_y",   32'(ifa.y),   32'(8'h20 ^ c_MASK));
      #2 rst = 1'b1;
      #1;
      check("async_y",    32'(ifa.y),    32'(c_MASK));
      check("async_cur",  32'(ifa.cur),  32'd0);
      check("async_busy", 32'(ifa.busy), 32'd0);
      #1 rst = 1'b0;

      ifa.load = 1'b1; ifa.mode = 1'b0; ifa.sel = 3'd5;
      cyc();
      ifa.load = 1'b0;
      check("dir_y",    32'(ifa.y),    32'(8'h20 ^ c_MASK));
      check("dir_cur",  32'(ifa.cur),  32'd5);
      check("dir_busy", 32'(ifa.busy), 32'd0);
      for (int i = 0; i < 10; i++) begin
         cyc();
         check("dir_hold_y",   32'(ifa.y),   32'(8'h20 ^ c_MASK));
         check("dir_hold_cur", 32'(ifa.cur), 32'd5);
      end

      // Scan from 6 with DWELL=4: 6,6,6,6,7,7,7,7,0(wrap),0,0,0,1..1,2
      ifa.load = 1'b1; ifa.mode = 1'b1; ifa.sel = 3'd6;
      cyc();
      ifa.load = 1'b0;
      for (int k = 0; k <= 16; k++) begin
         exp_cur = (6 + k / 4) % 8;
         check("scan_cur",  32'(ifa.cur),  32'(exp_cur));
         check("scan_y",    32'(ifa.y),    32'(ye(exp_cur)));
         check("scan_busy", 32'(ifa.busy), 32'd1);
         check("scan_wrap", 32'(ifa.wrap), (k == 8) ? 32'd1 : 32'd0);
         check("scan_1hot", 32'($countones(ifa.y ^ c_MASK)), 32'd1);
         if (k < 16) cyc();
      end

      // Enable drop at cur=2; a load while disabled is ignored.
      ifa.en = 1'b0;
      cyc();
      check("en0_y",    32'(ifa.y),    32'(c_MASK));
      check("en0_busy", 32'(ifa.busy), 32'd0);
      check("en0_cur",  32'(ifa.cur),  32'd2);
      check("en0_wrap", 32'(ifa.wrap), 32'd0);
      ifa.load = 1'b1; ifa.mode = 1'b0; ifa.sel = 3'd4;
      cyc();
      ifa.load = 1'b0;
      check("en0_ld_y",   32'(ifa.y),   32'(c_MASK));
      check("en0_ld_cur", 32'(ifa.cur), 32'd2);

      ifa.en = 1'b1;
      cyc();
      check("idle_y",    32'(ifa.y),    32'(c_MASK));
      check("idle_busy", 32'(ifa.busy), 32'd0);

      // Reload while cur=7 with the dwell counter at 2.
      ifa.load = 1'b1; ifa.mode = 1'b1; ifa.sel = 3'd7;
      cyc();
      ifa.load = 1'b0;
      cyc();
      cyc();
      check("rl_pre_cur", 32'(ifa.cur), 32'd7);
      ifa.load = 1'b1; ifa.mode = 1'b1; ifa.sel = 3'd3;
      cyc();
      ifa.load = 1'b0;
      for (int k = 0; k <= 4; k++) begin
         exp_cur = (k < 4) ? 3 : 4;
         check("rl_cur",  32'(ifa.cur),  32'(exp_cur));
         check("rl_y",    32'(ifa.y),    32'(ye(exp_cur)));
         check("rl_wrap", 32'(ifa.wrap), 32'd0);
         if (k < 4) cyc();
      end

      // Scan -> direct switch via load with mode=0.
      ifa.load = 1'b1; ifa.mode = 1'b0; ifa.sel = 3'd1;
      cyc();
      ifa.load = 1'b0;
      check("s2d_busy", 32'(ifa.busy), 32'd0);
      check("s2d_y",    32'(ifa.y),    32'(8'h02 ^ c_MASK));
      repeat (6) cyc();
      check("s2d_hold_cur", 32'(ifa.cur), 32'd1);
      check("s2d_hold_y",   32'(ifa.y),   32'(8'h02 ^ c_MASK));

      // DWELL=1 instance: scan from 0, one line per cycle.
      ifb.en = 1'b1; ifb.load = 1'b1; ifb.mode = 1'b1; ifb.sel = 3'd0;
      cyc();
      ifb.load = 1'b0;
      for (int k = 0; k <= 16; k++) begin
         exp_cur = k % 8;
         check("d1_cur",  32'(ifb.cur),  32'(exp_cur));
         check("d1_y",    32'(ifb.y),    32'(ye(exp_cur)));
         check("d1_wrap", 32'(ifb.wrap), (k > 0 && exp_cur == 0) ? 32'd1 : 32'd0);
         check("d1_1hot", 32'($countones(ifb.y ^ c_MASK)), 32'd1);
         check("d1_busy", 32'(ifb.busy), 32'd1);
         if (k < 16) cyc();
      end

`ifdef DECODER_ACTIVE_LOW_EN
      ifb.load = 1'b1; ifb.mode = 1'b0; ifb.sel = 3'd2;
      cyc();
      ifb.load = 1'b0;
      check("al_dir_y", 32'(ifb.y), 32'h0000_00FB);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
